// File: rtl/fft_out_serializer_if.sv
// Beat input stream and word output stream of the FFT output serializer.
interface fft_out_serializer_if #(
    parameter int unsigned DW = 64
) ();
    logic          IN_VLD;
    logic          IN_RDY;
    logic [DW-1:0] D0;
    logic [DW-1:0] D1;
    logic [DW-1:0] D2;
    logic [DW-1:0] D3;
    logic [DW-1:0] D4;
    logic [DW-1:0] D5;
    logic [DW-1:0] D6;
    logic [DW-1:0] D7;
    logic          OUT_VLD;
    logic          OUT_RDY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_LAST;

    // Upstream core plus downstream sink view.
    modport master (
        output IN_VLD, D0, D1, D2, D3, D4, D5, D6, D7, OUT_RDY,
        input  IN_RDY, OUT_VLD, OUT_DATA, OUT_LAST
    );

    // Serializer view.
    modport slave (
        input  IN_VLD, D0, D1, D2, D3, D4, D5, D6, D7, OUT_RDY,
        output IN_RDY, OUT_VLD, OUT_DATA, OUT_LAST
    );
endinterface

// File: rtl/fft_out_serializer.sv
// Buffers 8-lane FFT result beats and streams them out one word per cycle, framed.
module fft_out_serializer #(
    parameter int unsigned DW          = 64,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FRAME_BEATS = 512
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic FRAME_START,
    output logic FRAME_DONE,
    output logic BUSY,
    fft_out_serializer_if.slave bus
);
    localparam int unsigned LANES = 8;
    localparam int unsigned LW    = 3;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW    = AW + 1;
    localparam int unsigned CW    = $clog2(FRAME_BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic [LW-1:0] lane_ptr;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          frame_done_q;

    logic [DW-1:0] mem [DEPTH][LANES];
    logic [DW-1:0] lanes_in [LANES];

    logic in_rdy_c;
    logic push_c;
    logic out_vld_c;
    logic accept_c;
    logic pop_c;
    logic last_c;

    // Handshake decode; everything here depends only on registered state and the two valid/ready inputs.
    always_comb begin
        in_rdy_c  = (state == RUN) && (count != NW'(DEPTH));
        push_c    = bus.IN_VLD && in_rdy_c;
        out_vld_c = (count != NW'(0));
        accept_c  = out_vld_c && bus.OUT_RDY;
        pop_c     = accept_c && (lane_ptr == LW'(LANES - 1));
        last_c    = out_vld_c && (lane_ptr == LW'(LANES - 1))
                    && (out_cnt == CW'(FRAME_BEATS - 1));
    end

    // Gather the lane words into an indexable beat.
    always_comb begin
        lanes_in[0] = bus.D0;
        lanes_in[1] = bus.D1;
        lanes_in[2] = bus.D2;
        lanes_in[3] = bus.D3;
        lanes_in[4] = bus.D4;
        lanes_in[5] = bus.D5;
        lanes_in[6] = bus.D6;
        lanes_in[7] = bus.D7;
    end

    // Output mapping; OUT_DATA is forced to zero whenever nothing is valid.
    always_comb begin
        bus.IN_RDY   = in_rdy_c;
        bus.OUT_VLD  = out_vld_c;
        bus.OUT_DATA = out_vld_c ? mem[rd_ptr][lane_ptr] : '0;
        bus.OUT_LAST = last_c;
        BUSY         = (state != IDLE);
        FRAME_DONE   = frame_done_q;
    end

    // Beat storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            for (int k = 0; k < int'(LANES); k++) begin
                mem[wr_ptr][k] <= lanes_in[k];
            end
        end
    end

    // Frame FSM, FIFO pointers and lane/beat counters.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lane_ptr     <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
                in_cnt <= in_cnt + CW'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + AW'(1);
                out_cnt <= out_cnt + CW'(1);
            end
            if (accept_c) begin
                lane_ptr <= lane_ptr + LW'(1);
            end

            case ({push_c, pop_c})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (FRAME_START) begin
                        state    <= RUN;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        lane_ptr <= '0;
                    end
                end
                RUN: begin
                    if (push_c && (in_cnt == CW'(FRAME_BEATS - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept_c && last_c) begin
                        state        <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
